// File: rtl/calc_pkg.sv
// Shared calculator types and keypad helpers.
// Keypad matrix layout and row/column decode functions.
package calc_pkg;

  typedef enum logic [3:0] {
    B_NUM_0 = 4'd0,
    B_NUM_1 = 4'd1,
    B_NUM_2 = 4'd2,
    B_NUM_3 = 4'd3,
    B_NUM_4 = 4'd4,
    B_NUM_5 = 4'd5,
    B_NUM_6 = 4'd6,
    B_NUM_7 = 4'd7,
    B_NUM_8 = 4'd8,
    B_NUM_9 = 4'd9,
    B_ADD   = 4'd10,
    B_SUB   = 4'd11,
    B_MUL   = 4'd12,
    B_DIV   = 4'd13,
    B_EQ    = 4'd14,
    B_DOT   = 4'd15
  } active_button_t;

  localparam int KeypadRows = 4;
  localparam int KeypadCols = 4;

  function automatic active_button_t keypad2button(
    input logic [1:0] row,
    input logic [1:0] col
  );
    active_button_t b;
    b = B_NUM_0;
    case ({row, col})
      4'd0:  b = B_NUM_1;
      4'd1:  b = B_NUM_2;
      4'd2:  b = B_NUM_3;
      4'd3:  b = B_ADD;
      4'd4:  b = B_NUM_4;
      4'd5:  b = B_NUM_5;
      4'd6:  b = B_NUM_6;
      4'd7:  b = B_SUB;
      4'd8:  b = B_NUM_7;
      4'd9:  b = B_NUM_8;
      4'd10: b = B_NUM_9;
      4'd11: b = B_MUL;
      4'd12: b = B_DOT;
      4'd13: b = B_NUM_0;
      4'd14: b = B_EQ;
      default: b = B_DIV;
    endcase
    return b;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for a one-hot vector.
  function automatic logic [1:0] row_enc(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      v[0]: r = 2'd0;
      v[1]: r = 2'd1;
      v[2]: r = 2'd2;
      v[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones (idle level of pulled-up lines).
module sync_2ff #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and decode.
// One new_input_o pulse per accepted physical press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SettleCycles   = 4,
  parameter int DebounceCycles = 50000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  output logic [3:0]     col_o,
  input  logic [3:0]     row_i,
  output active_button_t active_button_o,
  output logic           new_input_o
);

  localparam int MaxCyc = (SettleCycles > DebounceCycles) ?
                          SettleCycles : DebounceCycles;
  localparam int CntW = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] DebLast    = CntW'(DebounceCycles - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HOLD
  } state_t;

  state_t          state;
  logic [1:0]      col;
  logic [1:0]      row_cap;
  logic [3:0]      pat;
  logic [CntW-1:0] cnt;
  logic [3:0]      row_sync;
  logic [3:0]      row_act;

  sync_2ff #(
    .Width(KeypadRows)
  ) u_sync (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .d    (row_i),
    .q    (row_sync)
  );

  assign row_act = ~row_sync;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
    return (c == {CntW{1'b1}}) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= S_SCAN;
      col             <= 2'd0;
      col_o           <= 4'b1110;
      row_cap         <= 2'd0;
      pat             <= 4'd0;
      cnt             <= '0;
      active_button_o <= B_NUM_0;
      new_input_o     <= 1'b0;
    end else begin
      new_input_o <= 1'b0;
      unique case (state)
        S_SCAN: begin
          if (cnt == SettleLast) begin
            cnt <= '0;
            if (is_onehot(row_act)) begin
              row_cap <= row_enc(row_act);
              pat     <= row_act;
              state   <= S_DEBOUNCE;
            end else begin
              col   <= col + 2'd1;
              col_o <= col_drive(col + 2'd1);
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_DEBOUNCE: begin
          if (row_act != pat) begin
            state <= S_SCAN;
            cnt   <= '0;
          end else if (cnt == DebLast) begin
            active_button_o <= keypad2button(row_cap, col);
            new_input_o     <= 1'b1;
            state           <= S_HOLD;
            cnt             <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_HOLD: begin
          // Any key on this column restarts the release window.
          if (row_act != 4'd0) begin
            cnt <= '0;
          end else if (cnt == DebLast) begin
            state <= S_SCAN;
            cnt   <= '0;
            col   <= col + 2'd1;
            col_o <= col_drive(col + 2'd1);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= S_SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner.
// Models a physical key matrix driving the DUT rows.
module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int Settle = 4;
  localparam int Deb    = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     col;
  logic [3:0]     row;
  active_button_t btn;
  logic           pulse;

  logic [15:0] keys;

  int checks;
  int failures;
  int pulses;
  int cyc;
  int last_pulse_cyc;
  logic prev_pulse;

  keypad_scanner #(
    .SettleCycles  (Settle),
    .DebounceCycles(Deb)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .col_o          (col),
    .row_i          (row),
    .active_button_o(btn),
    .new_input_o    (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to its driven-low column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (pulse === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
      checks++;
      if (prev_pulse === 1'b1) begin
        failures++;
        $display("FAIL pulse_back_to_back actual=1 expected=0");
      end
    end
    prev_pulse = pulse;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int r, input int c, input int n);
    keys[r*4+c] = 1'b1;
    tick(n);
    keys = '0;
  endtask

  typedef struct {
    int             r;
    int             c;
    int             hold;
    active_button_t exp_btn;
    int             exp_pulses;
  } vec_t;

  vec_t           tbl[10];
  active_button_t layout[4][4];
  active_button_t model_btn;

  initial begin
    int p0;
    int stable_start;
    logic [3:0] seen;
    logic wrap;
    logic [3:0] prev_col;
    int r;
    int c;
    int n;
    logic glitch;

    layout = '{'{B_NUM_1, B_NUM_2, B_NUM_3, B_ADD},
               '{B_NUM_4, B_NUM_5, B_NUM_6, B_SUB},
               '{B_NUM_7, B_NUM_8, B_NUM_9, B_MUL},
               '{B_DOT,   B_NUM_0, B_EQ,    B_DIV}};
    tbl[0] = '{1, 1, 40, B_NUM_5, 1};
    tbl[1] = '{2, 1, 2,  B_NUM_5, 0};
    tbl[2] = '{3, 2, 40, B_EQ,    1};
    tbl[3] = '{0, 3, 40, B_ADD,   1};
    tbl[4] = '{3, 0, 40, B_DOT,   1};
    tbl[5] = '{0, 0, 40, B_NUM_1, 1};
    tbl[6] = '{2, 3, 40, B_MUL,   1};
    tbl[7] = '{3, 3, 40, B_DIV,   1};
    tbl[8] = '{1, 3, 40, B_SUB,   1};
    tbl[9] = '{3, 1, 40, B_NUM_0, 1};

    checks = 0;
    failures = 0;
    pulses = 0;
    cyc = 0;
    last_pulse_cyc = 0;
    prev_pulse = 1'b0;
    keys = '0;
    rst_n = 1'b0;
    tick(1);
    tick(1);
    check("rst_col", col, 4'b1110);
    check("rst_pulse", pulse, 1'b0);
    check("rst_btn", btn, B_NUM_0);
    rst_n = 1'b1;
    tick(5);

    for (int i = 0; i < 10; i++) begin
      p0 = pulses;
      press(tbl[i].r, tbl[i].c, tbl[i].hold);
      tick(40);
      check("tbl_pulses", pulses - p0, tbl[i].exp_pulses);
      check("tbl_btn", btn, tbl[i].exp_btn);
    end

    // Bouncing '=' then stable.
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      keys[3*4+2] = ((i / 3) % 2) == 0;
      tick(1);
    end
    keys[3*4+2] = 1'b1;
    stable_start = cyc;
    tick(40);
    keys = '0;
    tick(40);
    check("bounce_pulses", pulses - p0, 1);
    check("bounce_btn", btn, B_EQ);
    check("bounce_after_stable", last_pulse_cyc > stable_start, 1);

    // Key 5 held, release bounce, then '+'.
    p0 = pulses;
    keys[1*4+1] = 1'b1;
    for (int i = 0; i < 100 && pulses == p0; i++) tick(1);
    check("hold5_seen", pulses > p0, 1);
    tick(3 * Deb);
    check("hold5_single", pulses - p0, 1);
    check("hold5_btn", btn, B_NUM_5);
    for (int i = 0; i < 16; i++) begin
      keys[1*4+1] = ((i / 4) % 2) == 1;
      tick(1);
    end
    keys = '0;
    tick(20);
    check("release_pulses", pulses - p0, 1);
    check("release_btn", btn, B_NUM_5);
    press(0, 3, 40);
    tick(40);
    check("add_pulses", pulses - p0, 2);
    check("add_btn", btn, B_ADD);

    // Two keys on column 0: rejected, scan keeps wrapping.
    p0 = pulses;
    keys[0*4+0] = 1'b1;
    keys[2*4+0] = 1'b1;
    seen = '0;
    wrap = 1'b0;
    prev_col = col;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      for (int k = 0; k < 4; k++) if (!col[k]) seen[k] = 1'b1;
      if (prev_col == 4'b0111 && col == 4'b1110) wrap = 1'b1;
      prev_col = col;
    end
    keys = '0;
    tick(20);
    check("multi_pulses", pulses - p0, 0);
    check("multi_cols_seen", seen, 4'b1111);
    check("multi_wrap", wrap, 1'b1);

    // Reset during debounce of key 9.
    p0 = pulses;
    keys[2*4+2] = 1'b1;
    for (int i = 0; i < 100 && col == 4'b1011; i++) tick(1);
    for (int i = 0; i < 100 && col != 4'b1011; i++) tick(1);
    check("rst9_col_reached", col, 4'b1011);
    tick(Settle + 2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rst9_col", col, 4'b1110);
    check("rst9_pulse", pulse, 1'b0);
    check("rst9_btn", btn, B_NUM_0);
    tick(60);
    keys = '0;
    tick(40);
    check("rst9_pulses", pulses - p0, 1);
    check("rst9_btn_after", btn, B_NUM_9);

    // Random presses and glitches against a press-level model.
    model_btn = B_NUM_9;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      glitch = ($urandom_range(0, 3) == 0);
      n = glitch ? $urandom_range(1, Deb - 1) : $urandom_range(40, 70);
      p0 = pulses;
      press(r, c, n);
      tick(40);
      if (!glitch) model_btn = layout[r][c];
      check("rand_pulses", pulses - p0, glitch ? 0 : 1);
      check("rand_btn", btn, model_btn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
